// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit
// Tracks in-flight conditional branches from decode, resolves the oldest one
// against the real outcome reported by EX, and drives predictor feedback,
// a one-cycle flush pulse and a held fetch redirect on a misprediction.
// Optional feature macro: BRANCH_STATS_EN (resolve / mispredict counters).
// Without it both statistics outputs are tied to zero.
module branch_resolution_unit #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_dec_valid,
    input  logic [ADDR_WIDTH-1:0] i_dec_pc,
    input  logic                  i_dec_prediction,
    input  logic [ADDR_WIDTH-1:0] i_dec_recovery_target,
    output logic                  o_dec_ready,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_outcome,
    output logic                  o_fb_valid,
    output logic [ADDR_WIDTH-1:0] o_fb_pc,
    output logic                  o_fb_prediction,
    output logic                  o_fb_outcome,
    output logic                  o_flush,
    output logic                  o_redirect_valid,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    input  logic                  i_redirect_ready,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_branch_count,
    output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    // Tracking queue storage
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic                  pred_q [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_q  [DEPTH];

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  dec_ready_q, dec_ready_d;
    logic                  fb_valid_q, fb_valid_d;
    logic [ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d;
    logic                  fb_pred_q, fb_pred_d;
    logic                  fb_out_q, fb_out_d;
    logic                  flush_q, flush_d;
    logic                  redir_valid_q, redir_valid_d;
    logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
    logic                  err_q, err_d;

    logic push_s;
    logic resolve_s;
    logic mispredict_s;
    logic err_set_s;

    // Decode accepted pushes, legal resolves and protocol violations
    always_comb begin
        push_s       = i_dec_valid & dec_ready_q;
        resolve_s    = i_ex_valid & (state_q == ST_IDLE) & (occ_q != {OCC_W{1'b0}});
        mispredict_s = resolve_s & (i_ex_outcome != pred_q[rd_ptr_q]);
        err_set_s    = (i_dec_valid & ~dec_ready_q) | (i_ex_valid & ~resolve_s);
    end

    // Next-state for queue pointers, FSM and all registered outputs
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        occ_d         = occ_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict_s) begin
                    // Everything younger than the head is wrong-path, including
                    // a branch pushed in this same cycle.
                    state_d       = ST_REDIRECT;
                    wr_ptr_d      = {PTR_W{1'b0}};
                    rd_ptr_d      = {PTR_W{1'b0}};
                    occ_d         = {OCC_W{1'b0}};
                    redir_valid_d = 1'b1;
                    redir_pc_d    = tgt_q[rd_ptr_q];
                end else begin
                    if (push_s) begin
                        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    if (resolve_s) begin
                        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
                    end else begin
                        rd_ptr_d = rd_ptr_q;
                    end
                    occ_d = occ_q + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, resolve_s};
                end
            end
            ST_REDIRECT: begin
                if (i_redirect_ready) begin
                    state_d       = ST_IDLE;
                    redir_valid_d = 1'b0;
                end else begin
                    state_d       = ST_REDIRECT;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                wr_ptr_d      = {PTR_W{1'b0}};
                rd_ptr_d      = {PTR_W{1'b0}};
                occ_d         = {OCC_W{1'b0}};
                redir_valid_d = 1'b0;
            end
        endcase

        dec_ready_d = (occ_d != FULL_OCC) & (state_d == ST_IDLE);
        flush_d     = mispredict_s;
        err_d       = err_q | err_set_s;

        fb_valid_d = resolve_s;
        if (resolve_s) begin
            fb_pc_d   = pc_q[rd_ptr_q];
            fb_pred_d = pred_q[rd_ptr_q];
            fb_out_d  = i_ex_outcome;
        end else begin
            fb_pc_d   = {ADDR_WIDTH{1'b0}};
            fb_pred_d = 1'b0;
            fb_out_d  = 1'b0;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            occ_q         <= {OCC_W{1'b0}};
            dec_ready_q   <= 1'b0;
            fb_valid_q    <= 1'b0;
            fb_pc_q       <= {ADDR_WIDTH{1'b0}};
            fb_pred_q     <= 1'b0;
            fb_out_q      <= 1'b0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= {ADDR_WIDTH{1'b0}};
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            dec_ready_q   <= dec_ready_d;
            fb_valid_q    <= fb_valid_d;
            fb_pc_q       <= fb_pc_d;
            fb_pred_q     <= fb_pred_d;
            fb_out_q      <= fb_out_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            err_q         <= err_d;
        end
    end

    // Queue entry write; a push coinciding with a mispredict is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= {ADDR_WIDTH{1'b0}};
                pred_q[i] <= 1'b0;
                tgt_q[i]  <= {ADDR_WIDTH{1'b0}};
            end
        end else if (push_s && !mispredict_s) begin
            pc_q[wr_ptr_q]   <= i_dec_pc;
            pred_q[wr_ptr_q] <= i_dec_prediction;
            tgt_q[wr_ptr_q]  <= i_dec_recovery_target;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_WIDTH-1:0] br_cnt_q;
    logic [CNT_WIDTH-1:0] mp_cnt_q;

    // Resolve and mispredict statistics, wrapping naturally at full width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= {CNT_WIDTH{1'b0}};
            mp_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            if (resolve_s) begin
                br_cnt_q <= br_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (mispredict_s) begin
                mp_cnt_q <= mp_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_branch_count     = br_cnt_q;
    assign o_mispredict_count = mp_cnt_q;
`else
    assign o_branch_count     = {CNT_WIDTH{1'b0}};
    assign o_mispredict_count = {CNT_WIDTH{1'b0}};
`endif

    assign o_dec_ready      = dec_ready_q;
    assign o_fb_valid       = fb_valid_q;
    assign o_fb_pc          = fb_pc_q;
    assign o_fb_prediction  = fb_pred_q;
    assign o_fb_outcome     = fb_out_q;
    assign o_flush          = flush_q;
    assign o_redirect_valid = redir_valid_q;
    assign o_redirect_pc    = redir_pc_q;
    assign o_err            = err_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed testbench for branch_resolution_unit (DEPTH=4, 32-bit PCs).
module tb_branch_resolution_unit;

    logic        clk;
    logic        rst_n;
    logic        i_dec_valid;
    logic [31:0] i_dec_pc;
    logic        i_dec_prediction;
    logic [31:0] i_dec_recovery_target;
    logic        o_dec_ready;
    logic        i_ex_valid;
    logic        i_ex_outcome;
    logic        o_fb_valid;
    logic [31:0] o_fb_pc;
    logic        o_fb_prediction;
    logic        o_fb_outcome;
    logic        o_flush;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        i_redirect_ready;
    logic        o_err;
    logic [31:0] o_branch_count;
    logic [31:0] o_mispredict_count;

    int tests_run;
    int tests_failed;

    branch_resolution_unit #(.DEPTH(4), .ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_dec_valid           (i_dec_valid),
        .i_dec_pc              (i_dec_pc),
        .i_dec_prediction      (i_dec_prediction),
        .i_dec_recovery_target (i_dec_recovery_target),
        .o_dec_ready           (o_dec_ready),
        .i_ex_valid            (i_ex_valid),
        .i_ex_outcome          (i_ex_outcome),
        .o_fb_valid            (o_fb_valid),
        .o_fb_pc               (o_fb_pc),
        .o_fb_prediction       (o_fb_prediction),
        .o_fb_outcome          (o_fb_outcome),
        .o_flush               (o_flush),
        .o_redirect_valid      (o_redirect_valid),
        .o_redirect_pc         (o_redirect_pc),
        .i_redirect_ready      (i_redirect_ready),
        .o_err                 (o_err),
        .o_branch_count        (o_branch_count),
        .o_mispredict_count    (o_mispredict_count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs sampled 1 ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_dec_valid           = 1'b0;
        i_dec_pc              = 32'h0;
        i_dec_prediction      = 1'b0;
        i_dec_recovery_target = 32'h0;
        i_ex_valid            = 1'b0;
        i_ex_outcome          = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        i_dec_valid           = 1'b1;
        i_dec_pc              = pc;
        i_dec_prediction      = pred;
        i_dec_recovery_target = tgt;
    endtask

    task automatic set_resolve(input logic outcome);
        i_ex_valid   = 1'b1;
        i_ex_outcome = outcome;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"},  {63'h0, o_dec_ready}, 64'h0);
        check_eq({tag, "_fbv"},    {63'h0, o_fb_valid}, 64'h0);
        check_eq({tag, "_fbpc"},   {32'h0, o_fb_pc}, 64'h0);
        check_eq({tag, "_flush"},  {63'h0, o_flush}, 64'h0);
        check_eq({tag, "_rdv"},    {63'h0, o_redirect_valid}, 64'h0);
        check_eq({tag, "_rdpc"},   {32'h0, o_redirect_pc}, 64'h0);
        check_eq({tag, "_err"},    {63'h0, o_err}, 64'h0);
        check_eq({tag, "_bcnt"},   {32'h0, o_branch_count}, 64'h0);
        check_eq({tag, "_mcnt"},   {32'h0, o_mispredict_count}, 64'h0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        mp;
        int          exp_bc;
        int          exp_mc;

        tests_run        = 0;
        tests_failed     = 0;
        rst_n            = 1'b0;
        i_redirect_ready = 1'b0;
        idle_inputs();
        #3;
        check_reset_values("rst");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("ready_after_rst", {63'h0, o_dec_ready}, 64'h1);

        // ---- single correct TAKEN branch
        set_push(32'h100, 1'b1, 32'h104);
        cyc();
        idle_inputs();
        check_eq("t1_fbv_push", {63'h0, o_fb_valid}, 64'h0);
        set_resolve(1'b1);
        cyc();
        idle_inputs();
        check_eq("t1_fbv",   {63'h0, o_fb_valid}, 64'h1);
        check_eq("t1_fbpc",  {32'h0, o_fb_pc}, 64'h100);
        check_eq("t1_pred",  {63'h0, o_fb_prediction}, 64'h1);
        check_eq("t1_out",   {63'h0, o_fb_outcome}, 64'h1);
        check_eq("t1_flush", {63'h0, o_flush}, 64'h0);
        check_eq("t1_rdv",   {63'h0, o_redirect_valid}, 64'h0);
        cyc();
        check_eq("t1_fbv_drop", {63'h0, o_fb_valid}, 64'h0);

        // ---- mispredict with simultaneous push, slow redirect acceptance
        set_push(32'h200, 1'b0, 32'h300);
        cyc();
        set_push(32'h210, 1'b1, 32'h214);
        cyc();
        set_push(32'h220, 1'b1, 32'h224);
        set_resolve(1'b1);
        cyc();
        idle_inputs();
        check_eq("t2_flush", {63'h0, o_flush}, 64'h1);
        check_eq("t2_rdv",   {63'h0, o_redirect_valid}, 64'h1);
        check_eq("t2_rdpc",  {32'h0, o_redirect_pc}, 64'h300);
        check_eq("t2_ready", {63'h0, o_dec_ready}, 64'h0);
        check_eq("t2_fbpc",  {32'h0, o_fb_pc}, 64'h200);
        check_eq("t2_fbpred", {63'h0, o_fb_prediction}, 64'h0);
        check_eq("t2_fbout", {63'h0, o_fb_outcome}, 64'h1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_eq("t2_hold_flush", {63'h0, o_flush}, 64'h0);
            check_eq("t2_hold_rdv",   {63'h0, o_redirect_valid}, 64'h1);
            check_eq("t2_hold_rdpc",  {32'h0, o_redirect_pc}, 64'h300);
            check_eq("t2_hold_ready", {63'h0, o_dec_ready}, 64'h0);
        end
        i_redirect_ready = 1'b1;
        cyc();
        i_redirect_ready = 1'b0;
        check_eq("t2_acc_rdv",   {63'h0, o_redirect_valid}, 64'h0);
        check_eq("t2_acc_ready", {63'h0, o_dec_ready}, 64'h1);
        // queue must be empty: next resolved branch is the fresh one
        set_push(32'h400, 1'b1, 32'h404);
        cyc();
        idle_inputs();
        set_resolve(1'b1);
        cyc();
        idle_inputs();
        check_eq("t2_empty_fbpc", {32'h0, o_fb_pc}, 64'h400);
        check_eq("t2_err", {63'h0, o_err}, 64'h0);

        // ---- fill, overflow, then resolve+push with pointer wrap
        for (int k = 0; k < 4; k++) begin
            set_push(32'h500 + 32'(k) * 32'h10, 1'b0, 32'h900);
            cyc();
        end
        idle_inputs();
        check_eq("t3_full_ready", {63'h0, o_dec_ready}, 64'h0);
        check_eq("t3_err_before", {63'h0, o_err}, 64'h0);
        set_push(32'h5F0, 1'b0, 32'h900);
        cyc();
        idle_inputs();
        check_eq("t3_ovf_err", {63'h0, o_err}, 64'h1);
        set_resolve(1'b0);
        cyc();
        idle_inputs();
        check_eq("t3_pop0", {32'h0, o_fb_pc}, 64'h500);
        check_eq("t3_ready_after_pop", {63'h0, o_dec_ready}, 64'h1);
        for (int k = 0; k < 3; k++) begin
            set_push(32'h540 + 32'(k) * 32'h10, 1'b0, 32'h900);
            set_resolve(1'b0);
            cyc();
            idle_inputs();
            exp_pc = 32'h510 + 32'(k) * 32'h10;
            check_eq("t3_rp_fbpc", {32'h0, o_fb_pc}, {32'h0, exp_pc});
            check_eq("t3_rp_ready", {63'h0, o_dec_ready}, 64'h1);
        end
        for (int k = 0; k < 3; k++) begin
            set_resolve(1'b0);
            cyc();
            idle_inputs();
            exp_pc = 32'h540 + 32'(k) * 32'h10;
            check_eq("t3_drain_fbpc", {32'h0, o_fb_pc}, {32'h0, exp_pc});
            check_eq("t3_drain_flush", {63'h0, o_flush}, 64'h0);
        end

        // ---- asynchronous reset while a redirect is pending
        set_push(32'h600, 1'b1, 32'h700);
        cyc();
        idle_inputs();
        set_resolve(1'b0);
        cyc();
        idle_inputs();
        check_eq("t4_rdv", {63'h0, o_redirect_valid}, 64'h1);
        check_eq("t4_rdpc", {32'h0, o_redirect_pc}, 64'h700);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("t4_arst");
        cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("t4_ready_after", {63'h0, o_dec_ready}, 64'h1);
        check_eq("t4_rdv_after", {63'h0, o_redirect_valid}, 64'h0);

        // ---- statistics: 10 resolves, 3 mispredicts
        i_redirect_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mp = (k == 2) || (k == 5) || (k == 8);
            set_push(32'h800 + 32'(k) * 32'h4, 1'b1, 32'hA00);
            cyc();
            idle_inputs();
            set_resolve(~mp);
            cyc();
            idle_inputs();
            check_eq("t5_fbpc", {32'h0, o_fb_pc}, {32'h0, 32'h800 + 32'(k) * 32'h4});
            check_eq("t5_flush", {63'h0, o_flush}, {63'h0, mp});
            cyc();
        end
        i_redirect_ready = 1'b0;
`ifdef BRANCH_STATS_EN
        exp_bc = 10;
        exp_mc = 3;
`else
        exp_bc = 0;
        exp_mc = 0;
`endif
        check_eq("t5_bcnt", {32'h0, o_branch_count}, 64'(exp_bc));
        check_eq("t5_mcnt", {32'h0, o_mispredict_count}, 64'(exp_mc));
        check_eq("t5_err", {63'h0, o_err}, 64'h0);

        // ---- resolve on an empty queue: ignored, sticky error
        set_resolve(1'b1);
        cyc();
        idle_inputs();
        check_eq("t6_fbv", {63'h0, o_fb_valid}, 64'h0);
        check_eq("t6_err", {63'h0, o_err}, 64'h1);
        cyc();
        cyc();
        check_eq("t6_err_sticky", {63'h0, o_err}, 64'h1);
        check_eq("t6_bcnt", {32'h0, o_branch_count}, 64'(exp_bc));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
